sort_checker: RTL and testbench
===============================

Name: sort_checker

Overview:
- Downstream consumer of the merge tree's output stream (dot/doten).
- Checks that an N-record sorted run leaves the tree in nondecreasing key order and that the expected record count arrives.
- Reports pass/fail, the first failing beat and the record count.
- Replaces the XOR-sink used in frequency builds when functional sign-off on the board is needed; always ready, no back-pressure.

Parameters:
P_LOG, 0, log2 of records per output beat
DATW, 64, record width in bits
KEYW, 32, key width; key = low KEYW bits of each record
CNTW, 32, width of record/beat counters and TOTAL

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
START  in  1  one-cycle pulse; latch TOTAL, clear status, enter RUN
TOTAL  in  CNTW  expected record count for the run
DIN  in  DATW<<P_LOG  output beat of the merge tree; record 0 in the LSBs
DINEN  in  1  DIN valid this cycle
BUSY  out  1  high in RUN
DONE  out  1  high in DONE
ERR  out  1  sticky: order violation seen in this run
ERR_BEAT  out  CNTW  index of first beat with a violation (0-based)
OVR  out  1  sticky: DINEN seen while not in RUN, or beat arrived after count reached
REC_CNT  out  CNTW  records accepted in this run

Behaviour:
- Reset (async): state IDLE; all outputs 0; last-key register 0; first-beat flag set.
- FSM states:
  - IDLE: START -> RUN.
  - RUN: count reached -> DONE; START -> RUN (restart).
  - DONE: START -> RUN.
- START: TOTAL latched; ERR, ERR_BEAT, OVR and REC_CNT cleared; first-beat flag set; the beat in the START cycle is ignored.
- START with TOTAL=0: RUN for one cycle, then DONE; ERR=0.
- Pipeline:
  - S1 registers DIN/DINEN (accepted only in RUN).
  - S2 computes the ordering flags and updates the status registers.
  - A beat presented in cycle k updates REC_CNT/ERR/DONE visibly in cycle k+2.
- Intra-beat order: for j = 1..2^P_LOG-1, key[j] >= key[j-1], unsigned. Equal keys pass.
- Cross-beat order: key[0] of the beat must be >= the last key of the previous beat; skipped for the first beat after START.
- Violation: ERR set. ERR_BEAT gets the current beat index only if ERR was 0. ERR never clears except on START/RST.
- Last-key register always takes key[2^P_LOG-1] of the current beat, even on a violation, so one bad record flags once rather than cascading.
- REC_CNT += 2^P_LOG per accepted beat.
- RUN -> DONE when the updated REC_CNT >= TOTAL latched. A TOTAL that is not a multiple of the beat size completes on the beat that crosses it.
- DINEN in IDLE/DONE: data discarded, OVR set. Beats already in S1 when the count is reached are discarded and set OVR.
- Constraint: TOTAL <= 2^CNTW - 2^P_LOG, so counters never wrap. Not checked in hardware.
- START mid-run: the in-flight S1 beat is flushed, then the run restarts cleanly.

Optional Feature:
- Macro: SORT_CHECKER_CSUM_EN
- Defined:
  - Adds output CSUM [DATW-1:0] = XOR of every full record (key + payload) accepted in the run.
  - Cleared on START/RST; updated in S2 with the same k+2 latency as REC_CNT.
  - Compared by software against the XOR of the source records to catch lost or corrupted payloads.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/RUN/DONE).
  - A key-extract helper/constant for the key slice: low KEYW bits of a DATW record.
  - The P_LOG-derived records-per-beat constant.
- One sub-module: sort_checker_beat_cmp.
  - Combinational check of 2^P_LOG keys plus the previous last key.
  - Outputs the violation flag and the beat's last key.
  - Instantiated in S2.

Test Plan:
1. P_LOG=0, START TOTAL=4, beats with keys 1,2,2,5 on consecutive cycles -> DONE two cycles after the 4th beat, ERR=0, REC_CNT=4, OVR=0.
2. P_LOG=2, TOTAL=8, beats {1,3,4,9} then {9,10,12,20} -> DONE, ERR=0. Repeat with the second beat {8,10,12,20} -> ERR=1, ERR_BEAT=0x1.
3. P_LOG=2, beat 0 {1,5,3,7}, beat 2 also bad -> ERR=1, ERR_BEAT=0, not overwritten by beat 2; REC_CNT=12 at DONE with TOTAL=12.
4. DINEN pulses while IDLE, then one extra beat after DONE with TOTAL=2 -> OVR=1, REC_CNT unchanged (2).
5. RST asserted asynchronously mid-run (mid-cycle) -> all outputs 0 immediately. START during RUN with TOTAL=3 -> counters restart from 0; old ERR cleared.
6. CSUM_EN defined, P_LOG=0, records 0x1, 0x2, 0x4 -> CSUM=0x7 at DONE. START with TOTAL=0 -> DONE after one cycle, ERR=0.

Source files
------------

// File: rtl/sort_checker_pkg.sv
// Purpose: shared FSM encoding, default widths and beat-geometry helpers for sort_checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sort_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int P_LOG_DEF = 0;
  localparam int DATW_DEF  = 64;
  localparam int KEYW_DEF  = 32;
  localparam int CNTW_DEF  = 32;

  // The key is the low KEYW bits of each record.
  localparam int KEY_LSB = 0;

  function automatic int recs_per_beat(input int p_log);
    return 1 << p_log;
  endfunction

endpackage

// File: rtl/sort_checker_if.sv
// Purpose: bundle of control, data-in and status signals between the merge-tree sink side and sort_checker.
// Latency: n/a (wiring only).
// Backpressure: none; the checker is always ready, so the bundle carries no ready signal.
// Ports: START/TOTAL/DIN/DINEN driven by master; BUSY/DONE/ERR/ERR_BEAT/OVR/REC_CNT (+CSUM) by slave.
// Optional: CSUM present only when SORT_CHECKER_CSUM_EN is defined.
interface sort_checker_if
  import sort_checker_pkg::*;
#(
  parameter int P_LOG = P_LOG_DEF,
  parameter int DATW  = DATW_DEF,
  parameter int CNTW  = CNTW_DEF
);
  logic                     START;
  logic [CNTW-1:0]          TOTAL;
  logic [(DATW<<P_LOG)-1:0] DIN;
  logic                     DINEN;
  logic                     BUSY;
  logic                     DONE;
  logic                     ERR;
  logic [CNTW-1:0]          ERR_BEAT;
  logic                     OVR;
  logic [CNTW-1:0]          REC_CNT;
`ifdef SORT_CHECKER_CSUM_EN
  logic [DATW-1:0]          CSUM;

  modport master (
    output START, TOTAL, DIN, DINEN,
    input  BUSY, DONE, ERR, ERR_BEAT, OVR, REC_CNT, CSUM
  );
  modport slave (
    input  START, TOTAL, DIN, DINEN,
    output BUSY, DONE, ERR, ERR_BEAT, OVR, REC_CNT, CSUM
  );
`else
  modport master (
    output START, TOTAL, DIN, DINEN,
    input  BUSY, DONE, ERR, ERR_BEAT, OVR, REC_CNT
  );
  modport slave (
    input  START, TOTAL, DIN, DINEN,
    output BUSY, DONE, ERR, ERR_BEAT, OVR, REC_CNT
  );
`endif
endinterface

// File: rtl/sort_checker_beat_cmp.sv
// Purpose: flags an ordering violation inside one beat and against the previous beat's last key.
// Latency: combinational.
// Backpressure: none.
// Ports: keys (packed, key 0 in LSBs), prev_key, first (skip cross-beat check), viol, last_key.
module sort_checker_beat_cmp
  import sort_checker_pkg::*;
#(
  parameter int P_LOG = P_LOG_DEF,
  parameter int KEYW  = KEYW_DEF
) (
  input  logic [(KEYW<<P_LOG)-1:0] keys,
  input  logic [KEYW-1:0]          prev_key,
  input  logic                     first,
  output logic                     viol,
  output logic [KEYW-1:0]          last_key
);
  localparam int RPB = recs_per_beat(P_LOG);

  // Unsigned compares throughout; equal keys are in order.
  always_comb begin
    viol = !first && (keys[0 +: KEYW] < prev_key);
    for (int j = 1; j < RPB; j++) begin
      if (keys[j*KEYW +: KEYW] < keys[(j-1)*KEYW +: KEYW]) begin
        viol = 1'b1;
      end
    end
  end

  assign last_key = keys[(RPB-1)*KEYW +: KEYW];

endmodule

// File: rtl/sort_checker.sv
// Purpose: checks a sorted run from the merge tree for nondecreasing key order and record count.
// Latency: a beat presented in cycle k is reflected in REC_CNT/ERR/DONE (and CSUM) in cycle k+2.
// Backpressure: none; always accepts, beats outside a run are dropped and flagged on OVR.
// Ports: CLK, RST (async, active high), bus (sort_checker_if.slave: START/TOTAL/DIN/DINEN in, status out).
// Optional: SORT_CHECKER_CSUM_EN adds CSUM, the XOR of every record accepted in the run.
module sort_checker
  import sort_checker_pkg::*;
#(
  parameter int P_LOG = P_LOG_DEF,
  parameter int DATW  = DATW_DEF,
  parameter int KEYW  = KEYW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input logic           CLK,
  input logic           RST,
  sort_checker_if.slave bus
);
  localparam int              RPB     = recs_per_beat(P_LOG);
  localparam int              KVW     = KEYW * RPB;
  localparam logic [CNTW-1:0] RPB_CNT = CNTW'(RPB);

  state_t          state;
  state_t          state_nxt;
  logic            busy;
  logic            done;

  logic [KVW-1:0]  din_keys;
  logic            s1_vld;
  logic [KVW-1:0]  s1_keys;

  logic [CNTW-1:0] total_q;
  logic [CNTW-1:0] rec_cnt_q;
  logic [CNTW-1:0] rec_cnt_upd;
  logic [CNTW-1:0] err_beat_q;
  logic            err_q;
  logic            ovr_q;
  logic            first_q;
  logic [KEYW-1:0] last_key_q;

  logic            cmp_viol;
  logic [KEYW-1:0] cmp_last;
  logic            in_run;
  logic            s2_take;
  logic            cnt_hit;
  logic            stray_beat;

  // Only the key slices are needed for ordering, so S1 keeps just those.
  for (genvar j = 0; j < RPB; j++) begin : g_key
    assign din_keys[j*KEYW +: KEYW] = bus.DIN[j*DATW + KEY_LSB +: KEYW];
  end

  assign in_run      = (state == ST_RUN);
  // START flushes whatever sits in S1, so S2 never acts in a START cycle.
  assign s2_take     = s1_vld && in_run && !bus.START;
  assign rec_cnt_upd = s2_take ? (rec_cnt_q + RPB_CNT) : rec_cnt_q;
  assign cnt_hit     = (rec_cnt_upd >= total_q);
  // A beat offered outside RUN, or one caught in S1 when the count was reached.
  assign stray_beat  = !bus.START && !in_run && (bus.DINEN || s1_vld);

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.START) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (bus.START) begin
          state_nxt = ST_RUN;
        end else if (cnt_hit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (bus.START) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- S1: input register ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld  <= 1'b0;
      s1_keys <= '0;
    end else begin
      s1_vld <= bus.DINEN && in_run && !bus.START;
      if (bus.DINEN) s1_keys <= din_keys;
    end
  end

  // ---------------- S2: compare and status ----------------
  sort_checker_beat_cmp #(
    .P_LOG (P_LOG),
    .KEYW  (KEYW)
  ) u_beat_cmp (
    .keys     (s1_keys),
    .prev_key (last_key_q),
    .first    (first_q),
    .viol     (cmp_viol),
    .last_key (cmp_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      total_q    <= '0;
      rec_cnt_q  <= '0;
      err_beat_q <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      first_q    <= 1'b1;
      last_key_q <= '0;
    end else if (bus.START) begin
      total_q    <= bus.TOTAL;
      rec_cnt_q  <= '0;
      err_beat_q <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      if (s2_take) begin
        rec_cnt_q <= rec_cnt_upd;
        if (cmp_viol) begin
          err_q <= 1'b1;
          // REC_CNT is always a whole number of beats, so the shift is the beat index.
          if (!err_q) err_beat_q <= rec_cnt_q >> P_LOG;
        end
        // Track the beat's last key even on a violation so one bad record flags once.
        last_key_q <= cmp_last;
        first_q    <= 1'b0;
      end
      if (stray_beat) ovr_q <= 1'b1;
    end
  end

`ifdef SORT_CHECKER_CSUM_EN
  logic [(DATW<<P_LOG)-1:0] s1_dat;
  logic [DATW-1:0]          beat_x;
  logic [DATW-1:0]          csum_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_dat <= '0;
    end else if (bus.DINEN) begin
      s1_dat <= bus.DIN;
    end
  end

  always_comb begin
    beat_x = '0;
    for (int j = 0; j < RPB; j++) begin
      beat_x = beat_x ^ s1_dat[j*DATW +: DATW];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csum_q <= '0;
    end else if (bus.START) begin
      csum_q <= '0;
    end else if (s2_take) begin
      csum_q <= csum_q ^ beat_x;
    end
  end

  assign bus.CSUM = csum_q;
`endif

  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.ERR      = err_q;
  assign bus.ERR_BEAT = err_beat_q;
  assign bus.OVR      = ovr_q;
  assign bus.REC_CNT  = rec_cnt_q;

endmodule

// File: tb/tb_sort_checker.sv
// Purpose: self-checking bench for sort_checker at P_LOG=0 and P_LOG=2 fed from one shared stream.
// Latency: reference model predicts every status output each cycle.
// Backpressure: n/a (checker is always ready).
module tb_sort_checker;
  import sort_checker_pkg::*;

  localparam int DATW = 64;
  localparam int KEYW = 32;
  localparam int CNTW = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic              start;
  logic [CNTW-1:0]   total;
  logic [4*DATW-1:0] din;
  logic              dinen;

  sort_checker_if #(.P_LOG(0), .DATW(DATW), .CNTW(CNTW)) bus0 ();
  sort_checker_if #(.P_LOG(2), .DATW(DATW), .CNTW(CNTW)) bus2 ();

  assign bus0.START = start;
  assign bus0.TOTAL = total;
  assign bus0.DIN   = din[DATW-1:0];
  assign bus0.DINEN = dinen;
  assign bus2.START = start;
  assign bus2.TOTAL = total;
  assign bus2.DIN   = din;
  assign bus2.DINEN = dinen;

  sort_checker #(.P_LOG(0), .DATW(DATW), .KEYW(KEYW), .CNTW(CNTW)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );
  sort_checker #(.P_LOG(2), .DATW(DATW), .KEYW(KEYW), .CNTW(CNTW)) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_e;
  int unsigned       rpb_of [2] = '{1, 4};
  mode_e             m_mode [2];
  longint unsigned   m_total[2];
  longint unsigned   m_cnt  [2];
  longint unsigned   m_eb   [2];
  longint unsigned   m_last [2];
  bit                m_err  [2];
  bit                m_ovr  [2];
  bit                m_first[2];
  bit                m_pend [2];
  logic [4*DATW-1:0] m_pdat [2];
  logic [DATW-1:0]   m_csum [2];

  task automatic model_reset_one(input int i);
    m_mode[i]  = M_IDLE;
    m_total[i] = 0;
    m_cnt[i]   = 0;
    m_eb[i]    = 0;
    m_last[i]  = 0;
    m_err[i]   = 0;
    m_ovr[i]   = 0;
    m_first[i] = 1;
    m_pend[i]  = 0;
    m_pdat[i]  = '0;
    m_csum[i]  = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) model_reset_one(i);
  endtask

  // One clock edge of run-level behaviour: a beat offered in RUN is held for one
  // cycle, then scored if the run is still open, otherwise counted as overrun.
  task automatic model_edge(input int i);
    bit              was_run;
    bit              bad;
    int unsigned     n;
    longint unsigned seq[$];
    was_run = (m_mode[i] == M_RUN);
    n = rpb_of[i];
    if (RST) begin
      model_reset_one(i);
      return;
    end
    if (start) begin
      m_mode[i]  = M_RUN;
      m_total[i] = total;
      m_cnt[i]   = 0;
      m_eb[i]    = 0;
      m_err[i]   = 0;
      m_ovr[i]   = 0;
      m_first[i] = 1;
      m_pend[i]  = 0;
      m_csum[i]  = '0;
      return;
    end
    if (m_pend[i]) begin
      if (was_run) begin
        // Previous last key (unless first beat) followed by this beat's keys must not descend.
        if (!m_first[i]) seq.push_back(m_last[i]);
        for (int j = 0; j < int'(n); j++) seq.push_back(longint'(m_pdat[i][j*DATW +: KEYW]));
        bad = 0;
        for (int j = 1; j < seq.size(); j++) if (seq[j] < seq[j-1]) bad = 1;
        if (bad && !m_err[i]) m_eb[i] = m_cnt[i] / n;
        if (bad) m_err[i] = 1;
        m_last[i]  = seq[seq.size()-1];
        m_first[i] = 0;
        m_cnt[i]   = m_cnt[i] + n;
        for (int j = 0; j < int'(n); j++) m_csum[i] = m_csum[i] ^ m_pdat[i][j*DATW +: DATW];
      end else begin
        m_ovr[i] = 1;
      end
    end
    m_pend[i] = 0;
    if (was_run && m_cnt[i] >= m_total[i]) m_mode[i] = M_DONE;
    if (dinen) begin
      if (was_run) begin
        m_pend[i] = 1;
        m_pdat[i] = din;
      end else begin
        m_ovr[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check($sformatf("c%0d busy0", cyc), bus0.BUSY, m_mode[0] == M_RUN);
    check($sformatf("c%0d done0", cyc), bus0.DONE, m_mode[0] == M_DONE);
    check($sformatf("c%0d err0", cyc), bus0.ERR, m_err[0]);
    check($sformatf("c%0d err_beat0", cyc), bus0.ERR_BEAT, m_eb[0]);
    check($sformatf("c%0d ovr0", cyc), bus0.OVR, m_ovr[0]);
    check($sformatf("c%0d rec_cnt0", cyc), bus0.REC_CNT, m_cnt[0]);
    check($sformatf("c%0d busy2", cyc), bus2.BUSY, m_mode[1] == M_RUN);
    check($sformatf("c%0d done2", cyc), bus2.DONE, m_mode[1] == M_DONE);
    check($sformatf("c%0d err2", cyc), bus2.ERR, m_err[1]);
    check($sformatf("c%0d err_beat2", cyc), bus2.ERR_BEAT, m_eb[1]);
    check($sformatf("c%0d ovr2", cyc), bus2.OVR, m_ovr[1]);
    check($sformatf("c%0d rec_cnt2", cyc), bus2.REC_CNT, m_cnt[1]);
`ifdef SORT_CHECKER_CSUM_EN
    check($sformatf("c%0d csum0", cyc), bus0.CSUM, m_csum[0]);
    check($sformatf("c%0d csum2", cyc), bus2.CSUM, m_csum[1]);
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge CLK);
    cyc++;
    compare_all();
  endtask

  function automatic logic [4*DATW-1:0] mk(input logic [31:0] k0, input logic [31:0] k1,
                                           input logic [31:0] k2, input logic [31:0] k3,
                                           input bit pay);
    logic [31:0]       ks[4];
    logic [4*DATW-1:0] b;
    ks = '{k0, k1, k2, k3};
    for (int j = 0; j < 4; j++) b[j*DATW +: DATW] = {(pay ? 32'($urandom) : 32'h0), ks[j]};
    return b;
  endfunction

  task automatic beat(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2,
                      input logic [31:0] k3, input bit pay = 1'b1);
    start = 1'b0;
    din   = mk(k0, k1, k2, k3, pay);
    dinen = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    dinen = 1'b0;
    repeat (n) tick();
  endtask

  // The beat offered alongside START must be ignored, so offer one at random.
  task automatic do_start(input int unsigned tot);
    start = 1'b1;
    total = tot;
    dinen = 1'($urandom_range(0, 1));
    din   = mk($urandom, $urandom, $urandom, $urandom, 1'b1);
    tick();
    start = 1'b0;
    dinen = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    RST   = 1'b1;
    start = 1'b0;
    total = '0;
    din   = '0;
    dinen = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst busy0", bus0.BUSY, 0);
    check("rst rec_cnt2", bus2.REC_CNT, 0);
    RST = 1'b0;

    // Stray beats while IDLE.
    beat(7, 8, 9, 10);
    idle(2);
    check("idle ovr0", bus0.OVR, 1);
    check("idle ovr2", bus2.OVR, 1);

    // TOTAL=2 run, then one extra beat after DONE.
    do_start(2);
    check("t4 ovr cleared0", bus0.OVR, 0);
    beat(1, 1, 1, 1);
    beat(2, 2, 2, 2);
    idle(2);
    check("t4 done0", bus0.DONE, 1);
    check("t4 ovr before0", bus0.OVR, 0);
    beat(3, 3, 3, 3);
    idle(2);
    check("t4 ovr after0", bus0.OVR, 1);
    check("t4 rec_cnt0", bus0.REC_CNT, 2);

    // Keys 1,2,2,5 with TOTAL=4; DONE exactly two cycles after the last beat.
    do_start(4);
    beat(1, 1, 1, 1);
    beat(2, 2, 2, 2);
    beat(2, 2, 2, 2);
    beat(5, 5, 5, 5);
    check("t1 early done0", bus0.DONE, 0);
    idle(1);
    check("t1 done0", bus0.DONE, 1);
    check("t1 err0", bus0.ERR, 0);
    check("t1 rec_cnt0", bus0.REC_CNT, 4);
    check("t1 ovr0", bus0.OVR, 0);

    // Two-beat runs, good then with a cross-beat drop.
    do_start(8);
    beat(1, 3, 4, 9);
    beat(9, 10, 12, 20);
    idle(1);
    check("t2a done2", bus2.DONE, 1);
    check("t2a err2", bus2.ERR, 0);
    do_start(8);
    beat(1, 3, 4, 9);
    beat(8, 10, 12, 20);
    idle(1);
    check("t2b err2", bus2.ERR, 1);
    check("t2b err_beat2", bus2.ERR_BEAT, 1);
    // Keys straddling the sign bit must compare unsigned.
    do_start(8);
    beat(32'h7fff_fff0, 32'h7fff_ffff, 32'h8000_0000, 32'h8000_0001);
    beat(32'hffff_fff0, 32'hffff_fff0, 32'hffff_fffe, 32'hffff_ffff);
    idle(1);
    check("t2c err2", bus2.ERR, 0);
    check("t2c done2", bus2.DONE, 1);

    // First bad beat wins ERR_BEAT.
    do_start(12);
    beat(1, 5, 3, 7);
    beat(7, 8, 9, 10);
    beat(11, 10, 12, 13);
    idle(1);
    check("t3 err2", bus2.ERR, 1);
    check("t3 err_beat2", bus2.ERR_BEAT, 0);
    check("t3 rec_cnt2", bus2.REC_CNT, 12);
    check("t3 done2", bus2.DONE, 1);

    // Asynchronous reset mid-cycle.
    do_start(100);
    beat(5, 5, 5, 5);
    beat(3, 3, 3, 3);
    idle(1);
    check("t5 err before rst0", bus0.ERR, 1);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check("t5 rst busy0", bus0.BUSY, 0);
    check("t5 rst err0", bus0.ERR, 0);
    check("t5 rst rec_cnt0", bus0.REC_CNT, 0);
    check("t5 rst ovr2", bus2.OVR, 0);
    check("t5 rst err_beat2", bus2.ERR_BEAT, 0);
    tick();
    RST = 1'b0;

    // Restart mid-run with a beat in flight.
    do_start(100);
    beat(9, 9, 9, 9);
    beat(1, 1, 1, 1);
    beat(2, 2, 2, 2);
    do_start(3);
    check("t5 restart err0", bus0.ERR, 0);
    check("t5 restart rec_cnt0", bus0.REC_CNT, 0);
    beat(1, 1, 1, 1);
    beat(2, 2, 2, 2);
    beat(3, 3, 3, 3);
    idle(1);
    check("t5 done0", bus0.DONE, 1);
    check("t5 rec_cnt0", bus0.REC_CNT, 3);

    // Records 1,2,4 with zero payload, then an empty run.
    do_start(3);
    beat(1, 1, 1, 1, 1'b0);
    beat(2, 2, 2, 2, 1'b0);
    beat(4, 4, 4, 4, 1'b0);
    idle(1);
    check("t6 done0", bus0.DONE, 1);
`ifdef SORT_CHECKER_CSUM_EN
    check("t6 csum0", bus0.CSUM, 64'h7);
`endif
    do_start(0);
    check("t6 busy0", bus0.BUSY, 1);
    idle(1);
    check("t6 zero done0", bus0.DONE, 1);
    check("t6 zero err0", bus0.ERR, 0);

    // Randomized runs: mostly sorted keys with occasional drops, gaps, late beats and restarts.
    for (int r = 0; r < 40; r++) begin
      int unsigned base;
      int unsigned nb;
      logic [31:0] k[4];
      do_start($urandom_range(0, 40));
      base = ($urandom_range(0, 3) == 0) ? 32'h7fff_ff80 : $urandom_range(16, 1000);
      nb = $urandom_range(0, 14);
      for (int b = 0; b < int'(nb); b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        for (int j = 0; j < 4; j++) begin
          base = base + $urandom_range(0, 3);
          k[j] = base;
          if ($urandom_range(0, 19) == 0) k[j] = base - $urandom_range(1, 8);
        end
        beat(k[0], k[1], k[2], k[3]);
      end
      if ($urandom_range(0, 5) != 0) idle($urandom_range(1, 4));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
